noc_egress_arbiter: RTL and testbench

//   Output side of the NoC switch: drains the four destination FIFOs filled by the ingress controller
//   and transmits their packets downstream over a valid/ready interface, one single-flit packet at a time.

---
 rtl/noc_egress_arbiter.sv | 143 ++++++++++++++
 tb/tb_noc_egress_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_egress_arbiter.sv
// noc_egress_arbiter
//   Output side of the NoC switch. Drains the four destination FIFOs with
//   round-robin fairness. Each single-flit packet goes downstream over a
//   valid/ready link, one packet at a time.
//
//   Ports
//     clk, rst       single clock; synchronous active-high reset
//     fifo_empty     per-FIFO empty flags (bit i = FIFO i)
//     fifo_rd_en     one-hot (or zero) pop strobe, only ever raised in IDLE
//     fifo_rd_data   packed FIFO read words, word i at [i*DATA_W +: DATA_W],
//                    valid one cycle after the matching pop
//     dst_valid      packet on dst_data/dst_port is valid
//     dst_ready      downstream accepts when dst_valid & dst_ready
//     dst_data       packet payload
//     dst_port       index of the FIFO the packet came from
//     busy           arbiter is not idle
//     tx_count       packets accepted downstream since reset (wraps)

module noc_egress_arbiter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            fifo_empty,
    output logic [3:0]            fifo_rd_en,
    input  logic [4*DATA_W-1:0]   fifo_rd_data,
    output logic                  dst_valid,
    input  logic                  dst_ready,
    output logic [DATA_W-1:0]     dst_data,
    output logic [1:0]            dst_port,
    output logic                  busy,
    output logic [CNT_W-1:0]      tx_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] rr_ptr;
    logic [1:0] winner;
    logic [1:0] grant;
    logic       grant_valid;
    logic [1:0] scan_idx;
    logic       handshake;

    // Round-robin pick: scan rr_ptr, rr_ptr+1, ... (mod 4) and take the
    // first non-empty FIFO. The 2-bit add gives the modulo wrap for free.
    always_comb begin
        grant       = rr_ptr;
        grant_valid = 1'b0;
        scan_idx    = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            scan_idx = rr_ptr + k[1:0];
            if (!grant_valid && !fifo_empty[scan_idx]) begin
                grant       = scan_idx;
                grant_valid = 1'b1;
            end
        end
    end

    // dst_valid is only ever high in SEND, but qualifying with it keeps
    // a stray dst_ready from being mistaken for an accepted packet.
    assign handshake = (state == SEND) && dst_valid && dst_ready;

    // Next-state and pop strobe. The pop is gated with rst so that no
    // FIFO word is consumed while the block is held in reset.
    always_comb begin
        next_state = state;
        fifo_rd_en = 4'b0000;
        case (state)
            IDLE: begin
                if (!rst && grant_valid) begin
                    fifo_rd_en[grant] = 1'b1;
                    next_state        = FETCH;
                end
            end
            FETCH: begin
                next_state = SEND;
            end
            SEND: begin
                if (handshake) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath. The winner is latched at pop time. It picks the FIFO word
    // one cycle later, when the read data is valid. It also sets the next
    // round-robin start once the packet has been accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= 2'd0;
            winner    <= 2'd0;
            dst_valid <= 1'b0;
            dst_data  <= '0;
            dst_port  <= 2'd0;
            tx_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        winner <= grant;
                    end
                end
                FETCH: begin
                    dst_data  <= fifo_rd_data[int'(winner)*DATA_W +: DATA_W];
                    dst_port  <= winner;
                    dst_valid <= 1'b1;
                end
                SEND: begin
                    if (handshake) begin
                        dst_valid <= 1'b0;
                        rr_ptr    <= winner + 2'd1;
                        tx_count  <= tx_count + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_noc_egress_arbiter.sv
// Testbench for noc_egress_arbiter.
//   The bench models the four FIFOs as small memories. Expected packets are
//   queued as the FIFOs are loaded. The per-cycle monitor pops them at each
//   downstream handshake. Two DUT instances share all inputs. The second
//   one has a 3-bit packet counter so that counter wrap can be reached in
//   a few packets.

module tb_noc_egress_arbiter;

    localparam int DATA_W  = 8;
    localparam int CNT_W   = 16;
    localparam int SMALL_W = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [3:0]          fifo_empty;
    logic [3:0]          fifo_rd_en;
    logic [4*DATA_W-1:0] fifo_rd_data;
    logic                dst_valid;
    logic                dst_ready;
    logic [DATA_W-1:0]   dst_data;
    logic [1:0]          dst_port;
    logic                busy;
    logic [CNT_W-1:0]    tx_count;

    logic [3:0]          s_rd_en;
    logic                s_valid;
    logic [DATA_W-1:0]   s_data;
    logic [1:0]          s_port;
    logic                s_busy;
    logic [SMALL_W-1:0]  s_tx;

    always #5 clk = ~clk;

    noc_egress_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .dst_valid    (dst_valid),
        .dst_ready    (dst_ready),
        .dst_data     (dst_data),
        .dst_port     (dst_port),
        .busy         (busy),
        .tx_count     (tx_count)
    );

    noc_egress_arbiter #(.DATA_W(DATA_W), .CNT_W(SMALL_W)) dut_small (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (s_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .dst_valid    (s_valid),
        .dst_ready    (dst_ready),
        .dst_data     (s_data),
        .dst_port     (s_port),
        .busy         (s_busy),
        .tx_count     (s_tx)
    );

    // FIFO models: the initial block writes the memory and wr_cnt, and the
    // pop process below owns rd_cnt and the read data.
    logic [7:0] fifo_mem [4][256];
    logic [7:0] wr_cnt [4];
    logic [7:0] rd_cnt [4] = '{default: 8'd0};

    for (genvar g = 0; g < 4; g++) begin : g_empty
        assign fifo_empty[g] = (wr_cnt[g] == rd_cnt[g]);
    end

    // Words not being popped get random data, so a wrong word select shows up.
    always @(posedge clk) begin
        for (int p = 0; p < 4; p++) begin
            if (fifo_rd_en[p] && !fifo_empty[p]) begin
                fifo_rd_data[p*8 +: 8] <= fifo_mem[p][rd_cnt[p]];
                rd_cnt[p]              <= rd_cnt[p] + 8'd1;
            end else begin
                fifo_rd_data[p*8 +: 8] <= 8'($urandom);
            end
        end
    end

    typedef struct packed {
        logic [1:0] port;
        logic [7:0] data;
    } pkt_t;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] data;
        int          stall;
        int          n;
        logic [7:0]  order;
    } vec_t;

    pkt_t       sb[$];
    vec_t       vecs[7];
    int         checks;
    int         passes;
    int         exp_tx;
    logic       stall_prev;
    logic [1:0] hold_port;
    logic [7:0] hold_data;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Per-cycle monitor, called on the falling edge while inputs are stable.
    task automatic sample_cycle();
        pkt_t exp_pkt;
        if (fifo_rd_en != 4'b0000) begin
            checkOutput("rd_en_legal",
                        {28'd0, $onehot(fifo_rd_en), ((fifo_rd_en & fifo_empty) == 4'b0000), busy, rst},
                        32'b1100);
        end
        if (stall_prev) begin
            checkOutput("stall_hold", {dst_valid, dst_port, dst_data}, {1'b1, hold_port, hold_data});
        end
        if (dst_valid && dst_ready && !rst) begin
            if (sb.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_pkt: got port %0d data 0x%0h, expected no packet",
                         dst_port, dst_data);
            end else begin
                exp_pkt = sb.pop_front();
                checkOutput("pkt", {dst_port, dst_data}, {exp_pkt.port, exp_pkt.data});
            end
        end
        stall_prev = dst_valid && !dst_ready && !rst;
        hold_port  = dst_port;
        hold_data  = dst_data;
    endtask

    // One clock: monitor at the falling edge, return 1 time unit after the
    // rising edge so that checks and new inputs see settled DUT outputs.
    task automatic tick();
        @(negedge clk);
        sample_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int p, input logic [7:0] d);
        fifo_mem[p][wr_cnt[p]] = d;
        wr_cnt[p]              = wr_cnt[p] + 8'd1;
    endtask

    task automatic expect_pkt(input logic [1:0] p, input logic [7:0] d);
        pkt_t e;
        e.port = p;
        e.data = d;
        sb.push_back(e);
        exp_tx++;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("[TB] FAIL %s: got %0d packets outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!dst_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput(name, {31'd0, dst_valid}, 32'd1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst    = 1'b0;
        exp_tx = 0;
        sb.delete();
    endtask

    // Load one table vector, queue its expected packet order, and hold
    // dst_ready low for the first 'stall' cycles.
    task automatic applyStimulus(input int idx, input vec_t v);
        int         cyc;
        logic [1:0] p;
        dst_ready = (v.stall == 0);
        for (int i = 0; i < 4; i++) begin
            if (v.mask[i]) push_word(i, v.data[i*8 +: 8]);
        end
        for (int k = 0; k < v.n; k++) begin
            p = v.order[2*k +: 2];
            expect_pkt(p, v.data[int'(p)*8 +: 8]);
        end
        cyc = 0;
        while (sb.size() != 0 && cyc < 60) begin
            tick();
            cyc++;
            if (cyc >= v.stall) dst_ready = 1'b1;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("[TB] FAIL vec%0d_timeout: got %0d packets outstanding, expected 0", idx, sb.size());
            sb.delete();
        end
        checkOutput($sformatf("vec%0d_end", idx), {14'd0, tx_count, busy, dst_valid},
                    {14'd0, 16'(exp_tx), 1'b0, 1'b0});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Expected grant order for each vector is worked out by hand from
        // the round-robin pointer left by the previous vector (start 0).
        vecs[0] = '{4'b1111, 32'h44332211, 0, 4, {2'd3, 2'd2, 2'd1, 2'd0}};
        vecs[1] = '{4'b0101, 32'h00C3005A, 0, 2, {2'd0, 2'd0, 2'd2, 2'd0}};
        vecs[2] = '{4'b1010, 32'hE7007E00, 0, 2, {2'd0, 2'd0, 2'd1, 2'd3}};
        vecs[3] = '{4'b0001, 32'h000000FF, 4, 1, {2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[4] = '{4'b1000, 32'h00000000, 0, 1, {2'd0, 2'd0, 2'd0, 2'd3}};
        vecs[5] = '{4'b0110, 32'h00966900, 3, 2, {2'd0, 2'd0, 2'd2, 2'd1}};
        vecs[6] = '{4'b1001, 32'h81000018, 0, 2, {2'd0, 2'd0, 2'd0, 2'd3}};

        checks     = 0;
        passes     = 0;
        exp_tx     = 0;
        stall_prev = 1'b0;
        hold_port  = 2'd0;
        hold_data  = 8'd0;
        for (int p = 0; p < 4; p++) wr_cnt[p] = 8'd0;
        rst        = 1'b1;
        dst_ready  = 1'b0;
        repeat (3) tick();

        // Idle after reset; dst_ready high with nothing valid must be ignored.
        $display("[TB] reset and idle");
        rst       = 1'b0;
        dst_ready = 1'b1;
        repeat (10) begin
            tick();
            checkOutput("idle", {fifo_rd_en, dst_valid, busy, 16'(tx_count)}, 32'd0);
        end

        // Single packet from FIFO2, loaded while reset is still held.
        $display("[TB] single packet from FIFO2");
        rst = 1'b1;
        tick();
        push_word(2, 8'hA5);
        #1;
        checkOutput("rst_hold_rd_en", {28'd0, fifo_rd_en}, 32'd0);
        tick();
        rst    = 1'b0;
        exp_tx = 0;
        expect_pkt(2'd2, 8'hA5);
        #1;
        checkOutput("fifo2_c0_rd_en", {28'd0, fifo_rd_en}, 32'b0100);
        tick();
        checkOutput("fifo2_c1", {26'd0, fifo_rd_en, dst_valid, busy}, {26'd0, 4'b0000, 1'b0, 1'b1});
        tick();
        checkOutput("fifo2_c2", {21'd0, dst_valid, dst_data, dst_port}, {21'd0, 1'b1, 8'hA5, 2'd2});
        tick();
        checkOutput("fifo2_done", {14'd0, tx_count, busy, dst_valid}, {14'd0, 16'd1, 1'b0, 1'b0});

        // Pointer now 3: FIFO3 must win over FIFO0.
        push_word(0, 8'h10);
        push_word(3, 8'h13);
        expect_pkt(2'd3, 8'h13);
        expect_pkt(2'd0, 8'h10);
        drain("ptr3_drain", 30);

        // Table-driven vectors from a fresh reset.
        $display("[TB] table vectors");
        dst_ready = 1'b0;
        do_reset(2);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Backpressure: FIFO1 packet held for five stalled cycles.
        $display("[TB] backpressure stall");
        dst_ready = 1'b0;
        push_word(1, 8'h3C);
        expect_pkt(2'd1, 8'h3C);
        wait_valid("stall_wait_valid");
        repeat (5) begin
            checkOutput("stall_out", {17'd0, dst_valid, dst_data, dst_port, fifo_rd_en},
                        {17'd0, 1'b1, 8'h3C, 2'd1, 4'b0000});
            tick();
        end
        dst_ready = 1'b1;
        tick();
        checkOutput("stall_done", {14'd0, tx_count, busy, dst_valid},
                    {14'd0, 16'(exp_tx), 1'b0, 1'b0});
        repeat (3) tick();
        checkOutput("stall_no_repeat", {14'd0, tx_count, busy, dst_valid},
                    {14'd0, 16'(exp_tx), 1'b0, 1'b0});

        // Move the pointer to 1, then keep FIFO0 and FIFO3 both non-empty.
        $display("[TB] fairness between FIFO0 and FIFO3");
        push_word(0, 8'h77);
        expect_pkt(2'd0, 8'h77);
        drain("fair_prep", 30);
        push_word(0, 8'hA0);
        push_word(0, 8'hA1);
        push_word(0, 8'hA2);
        push_word(3, 8'hB0);
        push_word(3, 8'hB1);
        push_word(3, 8'hB2);
        expect_pkt(2'd3, 8'hB0);
        expect_pkt(2'd0, 8'hA0);
        expect_pkt(2'd3, 8'hB1);
        expect_pkt(2'd0, 8'hA1);
        expect_pkt(2'd3, 8'hB2);
        expect_pkt(2'd0, 8'hA2);
        drain("fair_drain", 60);
        checkOutput("fair_count", {16'd0, tx_count}, {16'd0, 16'(exp_tx)});

        // Reset while a packet waits in SEND: the packet is lost.
        $display("[TB] reset during send");
        dst_ready = 1'b0;
        push_word(2, 8'h99);
        wait_valid("rst_send_wait_valid");
        checkOutput("rst_send_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        checkOutput("rst_send", {14'd0, dst_valid, busy, tx_count}, 32'd0);
        checkOutput("rst_send_small", {29'd0, s_tx}, 32'd0);
        rst       = 1'b0;
        exp_tx    = 0;
        sb.delete();
        dst_ready = 1'b1;
        tick();
        checkOutput("rst_send_idle", {26'd0, fifo_rd_en, dst_valid, busy}, 32'd0);

        // Counter wrap on the 3-bit instance: 7 packets, then one more.
        $display("[TB] counter wrap");
        for (int i = 0; i < 7; i++) begin
            push_word(i % 4, 8'(8'h40 + i));
            expect_pkt(2'(i % 4), 8'(8'h40 + i));
            drain("wrap_fill", 30);
        end
        checkOutput("wrap_pre", {13'd0, s_tx, tx_count}, {13'd0, 3'd7, 16'd7});
        push_word(3, 8'h4F);
        expect_pkt(2'd3, 8'h4F);
        drain("wrap_last", 30);
        checkOutput("wrap", {13'd0, s_tx, tx_count}, {13'd0, 3'd0, 16'd8});
        checkOutput("wrap_small_idle", {25'd0, s_rd_en, s_valid, s_busy, s_port},
                    {25'd0, 4'b0000, 1'b0, 1'b0, 2'd3});
        checkOutput("wrap_small_data", {24'd0, s_data}, 32'h4F);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
